pulse_window_ctrl: RTL and testbench

- Measurement sequencer for the pulse-monitor datapath.
- Owns the counting-window timebase: qualifies raw single-pulsed beats with a refractory lockout and emits the window-end strobe that clears the pulse counter and shifts the count-history registers.
- Tracks history fill, raises bpm_valid only when every history slot holds a full window, and detects loss of signal.
- Sits between single_pulser and the pulse_counter/pcount_registers pair, replacing the free-running delay counter.

---
 rtl/pulse_window_ctrl_pkg.sv | 21 ++
 rtl/pulse_window_ctrl_refractory_gate.sv | 51 +++++
 rtl/pulse_window_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_pulse_window_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_window_ctrl_pkg.sv
// Shared types and defaults for the pulse-monitor measurement sequencer.
package pulse_pkg;

  // Sequencer states; the encoding is visible on the debug/LED port.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2,
    LOST = 2'd3
  } state_t;

  localparam int unsigned CLK_HZ             = 32'd100_000_000;
  localparam int unsigned WIN_CYCLES_DEF     = 32'd500_000_000;
  localparam int unsigned REFRACT_CYCLES_DEF = 32'd20_000_000;

  // Bits needed to hold 0..n-1, never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 32'd1) ? int'($clog2(n)) : 32'd1;
  endfunction

endpackage

// File: rtl/pulse_window_ctrl_refractory_gate.sv
// Beat qualifier: refractory lockout after each accepted beat, and deferral of
// a beat that coincides with a window end into the following window.
module refractory_gate
  import pulse_pkg::*;
#(
  parameter int unsigned REFRACT_CYCLES = REFRACT_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic pulse_go,
  input  logic win_end,
  output logic pulse_ok
);

  localparam int unsigned    LW        = cnt_width(REFRACT_CYCLES);
  localparam logic [LW-1:0]  LOCK_LOAD = LW'(REFRACT_CYCLES - 32'd1);
  localparam logic [LW-1:0]  LOCK_ZERO = {LW{1'b0}};

  logic [LW-1:0] lock_q;
  logic [LW-1:0] lock_d;
  logic          pend_q;
  logic          pend_d;
  logic          accept_s;

  // Accept a beat, reload/decrement the lockout, and defer coincident beats.
  always_comb begin
    accept_s = active & pulse_go & (lock_q == LOCK_ZERO);
    if (accept_s) begin
      lock_d = LOCK_LOAD;
    end else if (lock_q != LOCK_ZERO) begin
      lock_d = lock_q - LW'(1);
    end else begin
      lock_d = lock_q;
    end
    pend_d   = accept_s & win_end;
    pulse_ok = active & ((accept_s & ~win_end) | pend_q);
  end

  // Lockout counter and pending-beat latch.
  always_ff @(posedge clk) begin
    if (!rst) begin
      lock_q <= LOCK_ZERO;
      pend_q <= 1'b0;
    end else begin
      lock_q <= lock_d;
      pend_q <= pend_d;
    end
  end

endmodule

// File: rtl/pulse_window_ctrl.sv
// Measurement sequencer: counting-window timebase, history fill tracking,
// BPM validity and loss-of-signal detection around a refractory beat gate.
module pulse_window_ctrl
  import pulse_pkg::*;
#(
  parameter int unsigned WIN_CYCLES     = WIN_CYCLES_DEF,
  parameter int unsigned REFRACT_CYCLES = REFRACT_CYCLES_DEF,
  parameter int unsigned NUM_WIN        = 32'd3,
  parameter int unsigned NOSIG_WINDOWS  = 32'd2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       pulse_go,
  output logic       pulse_ok,
  output logic       win_end,
  output logic       hist_clr,
  output logic [1:0] fill_cnt,
  output logic       bpm_valid,
  output logic       no_signal,
  output logic [1:0] state
);

  localparam int unsigned   CW        = cnt_width(WIN_CYCLES);
  localparam int unsigned   ZW        = cnt_width(NOSIG_WINDOWS);
  localparam logic [CW-1:0] WIN_LAST  = CW'(WIN_CYCLES - 32'd1);
  localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
  localparam logic [ZW-1:0] ZERO_LAST = ZW'(NOSIG_WINDOWS - 32'd1);
  localparam logic [ZW-1:0] ZERO_NONE = {ZW{1'b0}};
  localparam logic [1:0]    FILL_FULL = 2'(NUM_WIN);
  localparam logic [1:0]    FILL_LAST = 2'(NUM_WIN - 32'd1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    fill_q, fill_d;
  logic          bpm_q, bpm_d;
  logic          nosig_q, nosig_d;
  logic [ZW-1:0] zero_q, zero_d;
  logic          seen_q, seen_d;

  logic          active_s;
  logic          win_end_s;
  logic          lost_now_s;
  logic          hist_clr_s;
  logic          pulse_ok_s;
  logic [CW-1:0] cnt_next_s;

  refractory_gate #(
    .REFRACT_CYCLES(REFRACT_CYCLES)
  ) u_gate (
    .clk     (clk),
    .rst     (rst),
    .active  (active_s),
    .pulse_go(pulse_go),
    .win_end (win_end_s),
    .pulse_ok(pulse_ok_s)
  );

  // Window-end detection; suppressed in LOST and on the cycle enable drops.
  always_comb begin
    active_s   = enable & (state_q != IDLE);
    win_end_s  = enable & ((state_q == FILL) | (state_q == RUN)) & (cnt_q == WIN_LAST);
    lost_now_s = win_end_s & ~seen_q & (zero_q == ZERO_LAST);
    cnt_next_s = (cnt_q == WIN_LAST) ? CNT_ZERO : (cnt_q + CW'(1));
  end

  // Next-state logic for the FSM, timebase, fill, beat and zero-window tracking.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    fill_d     = fill_q;
    bpm_d      = bpm_q;
    nosig_d    = nosig_q;
    zero_d     = zero_q;
    seen_d     = seen_q;
    hist_clr_s = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      cnt_d   = CNT_ZERO;
      fill_d  = 2'd0;
      bpm_d   = 1'b0;
      nosig_d = 1'b0;
      zero_d  = ZERO_NONE;
      seen_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          hist_clr_s = 1'b1;
          state_d    = FILL;
          cnt_d      = CNT_ZERO;
          fill_d     = 2'd0;
          bpm_d      = 1'b0;
          nosig_d    = 1'b0;
          zero_d     = ZERO_NONE;
          seen_d     = 1'b0;
        end
        FILL, RUN: begin
          cnt_d = cnt_next_s;
          if (win_end_s) begin
            seen_d = 1'b0;
            if (lost_now_s) begin
              // Second consecutive empty window: history is meaningless now.
              state_d    = LOST;
              fill_d     = 2'd0;
              bpm_d      = 1'b0;
              nosig_d    = 1'b1;
              zero_d     = ZERO_NONE;
              hist_clr_s = 1'b1;
            end else begin
              zero_d = seen_q ? ZERO_NONE : (zero_q + ZW'(1));
              if ((state_q == FILL) && (fill_q != FILL_FULL)) begin
                fill_d = fill_q + 2'd1;
                if (fill_q == FILL_LAST) begin
                  state_d = RUN;
                  bpm_d   = 1'b1;
                end else begin
                  state_d = FILL;
                end
              end else begin
                fill_d = fill_q;
              end
            end
          end else if (pulse_ok_s) begin
            seen_d = 1'b1;
          end else begin
            seen_d = seen_q;
          end
        end
        LOST: begin
          if (pulse_ok_s) begin
            // Recovery beat restarts the window and counts toward it.
            state_d = FILL;
            cnt_d   = CNT_ZERO;
            nosig_d = 1'b0;
            zero_d  = ZERO_NONE;
            seen_d  = 1'b1;
          end else begin
            cnt_d = cnt_next_s;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = CNT_ZERO;
        end
      endcase
    end
  end

  // Sequencer state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= CNT_ZERO;
      fill_q  <= 2'd0;
      bpm_q   <= 1'b0;
      nosig_q <= 1'b0;
      zero_q  <= ZERO_NONE;
      seen_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fill_q  <= fill_d;
      bpm_q   <= bpm_d;
      nosig_q <= nosig_d;
      zero_q  <= zero_d;
      seen_q  <= seen_d;
    end
  end

  // Output drive.
  always_comb begin
    pulse_ok  = pulse_ok_s;
    win_end   = win_end_s;
    hist_clr  = hist_clr_s;
    fill_cnt  = fill_q;
    bpm_valid = bpm_q;
    no_signal = nosig_q;
    state     = state_q;
  end

endmodule

// File: tb/tb_pulse_window_ctrl.sv
// Self-checking bench for pulse_window_ctrl: directed scenarios followed by
// randomized beats/enable/reset, compared cycle by cycle against an
// event-level reference model.
module tb_pulse_window_ctrl;

  localparam int WIN   = 100;
  localparam int REF   = 10;
  localparam int NW    = 3;
  localparam int NOSIG = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       pulse_go;
  logic       pulse_ok;
  logic       win_end;
  logic       hist_clr;
  logic [1:0] fill_cnt;
  logic       bpm_valid;
  logic       no_signal;
  logic [1:0] state;

  pulse_window_ctrl #(
    .WIN_CYCLES    (WIN),
    .REFRACT_CYCLES(REF),
    .NUM_WIN       (NW),
    .NOSIG_WINDOWS (NOSIG)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .pulse_go (pulse_go),
    .pulse_ok (pulse_ok),
    .win_end  (win_end),
    .hist_clr (hist_clr),
    .fill_cnt (fill_cnt),
    .bpm_valid(bpm_valid),
    .no_signal(no_signal),
    .state    (state)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Sampled DUT outputs for the current cycle.
  int s_pok, s_we, s_hclr, s_fill, s_bpm, s_nosig, s_state;

  // Reference model: mode 0..3 = IDLE/FILL/RUN/LOST; windows are tracked by
  // their start cycle, lockout by the cycle of the last accepted beat.
  int m_mode, m_win_start, m_last_acc, m_beats, m_empty, m_fill;
  bit m_pending, m_bpm, m_nosig;
  bit e_active, e_we, e_acc, e_pok, e_loss, e_hclr;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: observed %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_win_start = 0; m_last_acc = -1000000;
    m_beats = 0; m_empty = 0; m_fill = 0;
    m_pending = 1'b0; m_bpm = 1'b0; m_nosig = 1'b0;
  endtask

  task automatic model_eval(input bit e, input bit g);
    e_active = e && (m_mode != 0);
    e_we     = e && (m_mode == 1 || m_mode == 2) && (((cyc - m_win_start) % WIN) == WIN - 1);
    e_acc    = e_active && g && ((cyc - m_last_acc) >= REF);
    e_pok    = e_active && ((e_acc && !e_we) || m_pending);
    e_loss   = e_we && (m_beats == 0) && (m_empty + 1 >= NOSIG);
    e_hclr   = (e && m_mode == 0) || e_loss;
  endtask

  task automatic model_step(input bit r, input bit e);
    if (!r) begin
      model_reset();
    end else begin
      if (e_acc) m_last_acc = cyc;
      m_pending = e_acc && e_we;
      if (!e) begin
        m_mode = 0; m_fill = 0; m_bpm = 1'b0; m_nosig = 1'b0; m_empty = 0; m_beats = 0;
      end else begin
        case (m_mode)
          0: begin
            m_mode = 1; m_win_start = cyc + 1; m_beats = 0; m_empty = 0;
          end
          1, 2: begin
            if (e_we) begin
              if (e_loss) begin
                m_mode = 3; m_fill = 0; m_bpm = 1'b0; m_nosig = 1'b1; m_empty = 0;
              end else begin
                m_empty = (m_beats > 0) ? 0 : m_empty + 1;
                if (m_mode == 1) begin
                  m_fill++;
                  if (m_fill == NW) begin
                    m_mode = 2; m_bpm = 1'b1;
                  end
                end
              end
              m_beats = 0;
            end else if (e_pok) begin
              m_beats++;
            end
          end
          3: begin
            if (e_pok) begin
              m_mode = 1; m_win_start = cyc + 1; m_nosig = 1'b0; m_empty = 0; m_beats = 1;
            end
          end
          default: m_mode = 0;
        endcase
      end
    end
  endtask

  // One clock cycle: drive, sample on the falling edge, compare, advance.
  task automatic tick(input bit r, input bit e, input bit g);
    rst = r; enable = e; pulse_go = g;
    @(negedge clk);
    s_pok = int'(pulse_ok); s_we = int'(win_end); s_hclr = int'(hist_clr);
    s_fill = int'(fill_cnt); s_bpm = int'(bpm_valid); s_nosig = int'(no_signal);
    s_state = int'(state);
    model_eval(e, g);
    if (r) begin
      check_val("pulse_ok",  s_pok,   int'(e_pok));
      check_val("win_end",   s_we,    int'(e_we));
      check_val("hist_clr",  s_hclr,  int'(e_hclr));
      check_val("state",     s_state, m_mode);
      check_val("fill_cnt",  s_fill,  m_fill);
      check_val("bpm_valid", s_bpm,   int'(m_bpm));
      check_val("no_signal", s_nosig, int'(m_nosig));
    end
    @(posedge clk);
    model_step(r, e);
    cyc++;
    #1;
  endtask

  function automatic bit go_dir(input int i);
    if (i >= 5 && i <= 405 && ((i - 5) % 20) == 0) return 1'b1;
    if (i == 420 || i == 423 || i == 429 || i == 430) return 1'b1;
    if (i == 500 || i == 505 || i == 1000 || i == 1355) return 1'b1;
    if (i >= 1010 && i <= 1340 && ((i - 1010) % 20) == 0) return 1'b1;
    if (i == 1400 || i == 1411 || i == 1421) return 1'b1;
    return 1'b0;
  endfunction

  int win1_ok = 0;
  int lost_we = 0;
  int dens;
  bit r_v, e_v, g_v;

  initial begin
    rst = 1'b0; enable = 1'b0; pulse_go = 1'b0;
    model_reset();
    @(posedge clk); #1;
    repeat (3) tick(1'b0, 1'b0, 1'b0);
    repeat (2) tick(1'b1, 1'b0, 1'b1);
    check_val("reset_state", s_state, 0);
    check_val("reset_fill",  s_fill, 0);

    // Directed scenario: startup, refractory, coincidence, loss, disable, reset.
    for (int i = 0; i <= 1440; i++) begin
      r_v = (i != 1421);
      e_v = !(i >= 1350 && i < 1370);
      g_v = go_dir(i);
      tick(r_v, e_v, g_v);
      if (i >= 1 && i <= 100) win1_ok += s_pok;
      if (i >= 801 && i <= 999) lost_we += s_we;
      case (i)
        0:    check_val("startup_hist_clr", s_hclr, 1);
        100, 200, 300: check_val("startup_win_end", s_we, 1);
        101, 201, 301: check_val("startup_fill", s_fill, i / 100);
        420, 430: check_val("refract_accept", s_pok, 1);
        423, 429: check_val("refract_drop", s_pok, 0);
        501:  check_val("coinc_deferred_ok", s_pok, 1);
        505:  check_val("coinc_lockout_drop", s_pok, 0);
        800:  check_val("loss_hist_clr", s_hclr, 1);
        1001: check_val("recover_state", s_state, 1);
        1355: check_val("disabled_go_ignored", s_pok, 0);
        default: ;
      endcase
      if (i == 101) check_val("win1_pulse_count", win1_ok, 5);
      if (i == 300 || i == 1300) check_val("bpm_before_full", s_bpm, 0);
      if (i == 301 || i == 1301) check_val("bpm_after_full", s_bpm, 1);
      if (i == 500) begin
        check_val("coinc_win_end", s_we, 1);
        check_val("coinc_no_ok", s_pok, 0);
      end
      if (i == 801) begin
        check_val("lost_no_signal", s_nosig, 1);
        check_val("lost_bpm", s_bpm, 0);
        check_val("lost_fill", s_fill, 0);
        check_val("lost_state", s_state, 3);
      end
      if (i == 1000) begin
        check_val("lost_win_end_count", lost_we, 0);
        check_val("recover_beat_ok", s_pok, 1);
      end
      if (i == 1351) begin
        check_val("disable_state", s_state, 0);
        check_val("disable_bpm", s_bpm, 0);
        check_val("disable_fill", s_fill, 0);
        check_val("disable_win_end", s_we, 0);
      end
      if (i == 1422) begin
        check_val("midreset_state", s_state, 0);
        check_val("midreset_fill", s_fill, 0);
        check_val("midreset_ok", s_pok, 0);
        check_val("midreset_win_end", s_we, 0);
      end
    end

    // Randomized phase: beat density varies per segment, rare enable/reset events.
    e_v = 1'b1;
    for (int seg = 0; seg < 16; seg++) begin
      dens = int'($urandom_range(0, 3));
      for (int k = 0; k < 250; k++) begin
        r_v = ($urandom_range(0, 1999) != 0);
        if ($urandom_range(0, 299) == 0) e_v = !e_v;
        g_v = (dens != 0) && ($urandom_range(0, dens * 5) == 0);
        tick(r_v, e_v, g_v);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
